pin_bank_arbiter: RTL and testbench

//  Shares the 32-pin I/O bank between NREQ requesters (p1v core, debug/loader engines) ahead of the pad tristates.

---
 rtl/pin_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/pin_bank_arbiter.sv | 167 ++++++++++++++++
 tb/tb_pin_bank_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_arb_pkg.sv
// Shared types and constants for the I/O pin bank arbiter.
package pin_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_TURN
  } arb_state_t;

  localparam int PIN_COUNT = 32;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import pin_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          valid
);

  int best;
  int best_rank;
  int rank;

  // Rank each request by its wrapped distance from ptr and keep the closest one.
  always_comb begin
    best      = 0;
    best_rank = N;
    rank      = 0;
    pick      = '0;
    for (int j = 0; j < N; j++) begin
      rank = j - int'(ptr);
      if (rank < 0) rank = rank + N;
      if (req[j] && (rank < best_rank)) begin
        best_rank = rank;
        best      = j;
      end
    end
    valid    = (best_rank < N);
    pick_idx = IW'(best);
    for (int j = 0; j < N; j++) begin
      pick[j] = valid && (j == best);
    end
  end

endmodule

// File: rtl/pin_bank_arbiter.sv
// Round-robin owner arbitration of the 32-pin I/O bank with a tristated
// turnaround between owners and optional revocation of long-running owners.
module pin_bank_arbiter
  import pin_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TURN_CYCLES = 4,
  parameter int MAX_HOLD    = 0
) (
  input  logic                      clock_160,
  input  logic                      res,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*PIN_COUNT-1:0] req_out,
  input  logic [NREQ*PIN_COUNT-1:0] req_dir,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           revoked,
  output logic [PIN_COUNT-1:0]      pin_out,
  output logic [PIN_COUNT-1:0]      pin_dir,
  output logic                      busy
);

  localparam int IW = idx_width(NREQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = $clog2(TURN_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  arb_state_t          state, state_nx;
  logic [IW-1:0]       rr_ptr, rr_ptr_nx;
  logic [HW-1:0]       hold_cnt, hold_nx;
  logic [TW-1:0]       turn_cnt, turn_nx;
  logic [NREQ-1:0]     grant_nx, revoked_nx;
  logic [PIN_COUNT-1:0] pin_out_nx, pin_dir_nx;
  logic                busy_nx;

  logic [NREQ-1:0]      pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [IW-1:0]        ptr_after;
  logic [PIN_COUNT-1:0] pick_out, pick_dir, own_out, own_dir;
  logic                 owner_req, others_req, revoke_due;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  assign ptr_after  = (pick_idx == IW'(NREQ - 1)) ? '0 : (pick_idx + 1'b1);
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign revoke_due = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST) && others_req;

  // Select pin vectors of the freshly picked requester and of the current owner.
  always_comb begin
    pick_out = '0;
    pick_dir = '0;
    own_out  = '0;
    own_dir  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k]) begin
        pick_out = req_out[k*PIN_COUNT +: PIN_COUNT];
        pick_dir = req_dir[k*PIN_COUNT +: PIN_COUNT];
      end
      if (grant[k]) begin
        own_out = req_out[k*PIN_COUNT +: PIN_COUNT];
        own_dir = req_dir[k*PIN_COUNT +: PIN_COUNT];
      end
    end
  end

  // Next-state and next-output logic; pins default to tristate with no owner.
  always_comb begin
    state_nx   = ARB_IDLE;
    rr_ptr_nx  = rr_ptr;
    hold_nx    = hold_cnt;
    turn_nx    = turn_cnt;
    grant_nx   = '0;
    revoked_nx = '0;
    pin_out_nx = '0;
    pin_dir_nx = '0;
    busy_nx    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nx   = ARB_OWN;
          grant_nx   = pick;
          pin_out_nx = pick_out;
          pin_dir_nx = pick_dir;
          rr_ptr_nx  = ptr_after;
          hold_nx    = '0;
          busy_nx    = 1'b1;
        end
      end
      ARB_OWN: begin
        busy_nx = 1'b1;
        if (!owner_req) begin
          state_nx = ARB_TURN;
          turn_nx  = '0;
        end else if (revoke_due) begin
          state_nx   = ARB_TURN;
          turn_nx    = '0;
          revoked_nx = grant;
        end else begin
          state_nx   = ARB_OWN;
          grant_nx   = grant;
          pin_out_nx = own_out;
          pin_dir_nx = own_dir;
          if (hold_cnt != HOLD_SAT) hold_nx = hold_cnt + 1'b1;
        end
      end
      ARB_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          if (pick_valid) begin
            state_nx   = ARB_OWN;
            grant_nx   = pick;
            pin_out_nx = pick_out;
            pin_dir_nx = pick_dir;
            rr_ptr_nx  = ptr_after;
            hold_nx    = '0;
            busy_nx    = 1'b1;
          end
        end else begin
          state_nx = ARB_TURN;
          turn_nx  = turn_cnt + 1'b1;
          busy_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = ARB_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clock_160) begin
    if (res) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      grant    <= '0;
      revoked  <= '0;
      pin_out  <= '0;
      pin_dir  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      hold_cnt <= hold_nx;
      turn_cnt <= turn_nx;
      grant    <= grant_nx;
      revoked  <= revoked_nx;
      pin_out  <= pin_out_nx;
      pin_dir  <= pin_dir_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_pin_bank_arbiter.sv
// Randomised and directed bench for pin_bank_arbiter against a behavioural model.
module tb_pin_bank_arbiter;

  localparam int NREQ = 2;
  localparam int TC   = 4;
  localparam int MH   = 16;

  logic        clock_160 = 1'b0;
  logic        res       = 1'b1;
  logic [1:0]  req       = '0;
  logic [63:0] req_out   = '0;
  logic [63:0] req_dir   = '0;
  logic [1:0]  grant;
  logic [1:0]  revoked;
  logic [31:0] pin_out;
  logic [31:0] pin_dir;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = owned, 2 = turnaround
  int          m_mode  = 0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  int          m_hold  = 0;
  int          m_turn  = 0;
  logic [1:0]  m_grant = '0;
  logic [1:0]  m_rev   = '0;
  logic [31:0] m_out   = '0;
  logic [31:0] m_dir   = '0;
  logic        m_busy  = 1'b0;

  pin_bank_arbiter #(
    .NREQ        (NREQ),
    .TURN_CYCLES (TC),
    .MAX_HOLD    (MH)
  ) dut (
    .clock_160 (clock_160),
    .res       (res),
    .req       (req),
    .req_out   (req_out),
    .req_dir   (req_dir),
    .grant     (grant),
    .revoked   (revoked),
    .pin_out   (pin_out),
    .pin_dir   (pin_dir),
    .busy      (busy)
  );

  always #5 clock_160 = ~clock_160;

  function automatic int reqBit(input logic [1:0] r, input int k);
    return (int'(r) >> k) & 1;
  endfunction

  function automatic logic [31:0] laneOf(input logic [63:0] v, input int k);
    logic [63:0] t;
    t = v >> (32 * k);
    return t[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelGrantNew();
    int pk;
    pk = -1;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (m_ptr + i) % NREQ;
      if (pk < 0 && reqBit(req, c) == 1) pk = c;
    end
    m_mode  = 1;
    m_owner = pk;
    m_ptr   = (pk + 1) % NREQ;
    m_hold  = 0;
    m_grant = 2'(1 << pk);
    m_out   = laneOf(req_out, pk);
    m_dir   = laneOf(req_dir, pk);
  endtask

  task automatic modelEnterTurn();
    m_mode  = 2;
    m_turn  = 0;
    m_grant = '0;
    m_out   = '0;
    m_dir   = '0;
  endtask

  task automatic modelEdge();
    int others;
    m_rev = '0;
    if (res) begin
      m_mode = 0; m_ptr = 0; m_hold = 0; m_turn = 0;
      m_grant = '0; m_out = '0; m_dir = '0;
    end else begin
      case (m_mode)
        0: if (req != 0) modelGrantNew();
        1: begin
          others = int'(req) & ~(1 << m_owner);
          if (reqBit(req, m_owner) == 0) begin
            modelEnterTurn();
          end else if (MH > 0 && m_hold == MH - 1 && others != 0) begin
            modelEnterTurn();
            m_rev = 2'(1 << m_owner);
          end else begin
            m_hold = (m_hold < MH) ? m_hold + 1 : MH;
            m_out  = laneOf(req_out, m_owner);
            m_dir  = laneOf(req_dir, m_owner);
          end
        end
        default: begin
          if (m_turn == TC - 1) begin
            if (req != 0) modelGrantNew();
            else m_mode = 0;
          end else begin
            m_turn++;
          end
        end
      endcase
    end
    m_busy = (m_mode != 0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare 1 ns later.
  task automatic applyStimulus(input logic r, input logic [1:0] rq);
    res = r;
    req = rq;
    @(posedge clock_160);
    modelEdge();
    #1;
    checkOutput("grant",   grant,   m_grant);
    checkOutput("revoked", revoked, m_rev);
    checkOutput("pin_out", pin_out, m_out);
    checkOutput("pin_dir", pin_dir, m_dir);
    checkOutput("busy",    busy,    m_busy);
  endtask

  initial begin
    int first_rev;
    int rev0_cnt;
    int rev1_cnt;
    logic [1:0] grant_at20;
    logic seen_g1;

    // Reset state
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b1, 2'b00);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dir", pin_dir, 0);

    // Single requester takes the bank
    req_out = {32'h1234_5678, 32'hA5A5_0F0F};
    req_dir = {32'h0000_FFFF, 32'hFFFF_0000};
    applyStimulus(1'b0, 2'b01);
    checkOutput("t1_grant", grant, 2'b01);
    checkOutput("t1_dir", pin_dir, 32'hFFFF_0000);
    checkOutput("t1_out", pin_out, 32'hA5A5_0F0F);
    checkOutput("t1_busy", busy, 1);

    // Release: four tristate cycles then idle
    applyStimulus(1'b0, 2'b00);
    checkOutput("t2_grant", grant, 0);
    checkOutput("t2_dir", pin_dir, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00);
      checkOutput("t2_turn_busy", busy, 1);
    end
    applyStimulus(1'b0, 2'b00);
    checkOutput("t2_idle_busy", busy, 0);

    // Both request from reset pointer; hand-over after turnaround
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b0, 2'b11);
    checkOutput("t3_grant0", grant, 2'b01);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b10);
    checkOutput("t3_turn_dir", pin_dir, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b0, 2'b10);
    checkOutput("t3_grant1", grant, 2'b10);
    checkOutput("t3_dir1", pin_dir, 32'h0000_FFFF);

    // Reset in the middle of an ownership
    req_dir = {32'hFFFF_FFFF, 32'hFFFF_0000};
    applyStimulus(1'b0, 2'b10);
    checkOutput("t5_dir_before", pin_dir, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'b10);
    checkOutput("t5_grant", grant, 0);
    checkOutput("t5_dir", pin_dir, 0);
    checkOutput("t5_out", pin_out, 0);
    applyStimulus(1'b0, 2'b01);
    checkOutput("t5_regrant", grant, 2'b01);

    // Revocation with both held: alternation with 16-cycle ownerships
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b0, 2'b11);
    checkOutput("t4_grant0", grant, 2'b01);
    first_rev = 0; rev0_cnt = 0; rev1_cnt = 0; grant_at20 = '0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b0, 2'b11);
      if (revoked != 0 && first_rev == 0) first_rev = i;
      if (revoked == 2'b01) rev0_cnt++;
      if (revoked == 2'b10) rev1_cnt++;
      if (i == 20) grant_at20 = grant;
    end
    checkOutput("t4_rev_cycle", first_rev, 16);
    checkOutput("t4_rev0_cnt", rev0_cnt, 1);
    checkOutput("t4_rev1_cnt", rev1_cnt, 1);
    checkOutput("t4_grant1", grant_at20, 2'b10);

    // Short pulse during turnaround is ignored
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b0, 2'b00);
    seen_g1 = 1'b0;
    applyStimulus(1'b0, 2'b11);
    if (grant == 2'b10) seen_g1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b01);
      if (grant == 2'b10) seen_g1 = 1'b1;
    end
    checkOutput("t6_grant", grant, 2'b01);
    checkOutput("t6_no_g1", seen_g1, 0);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] nr;
      logic       nres;
      nr = req;
      if ($urandom_range(5) == 0) nr[0] = ~nr[0];
      if ($urandom_range(5) == 0) nr[1] = ~nr[1];
      nres = ($urandom_range(299) == 0);
      req_out = {$urandom, $urandom};
      req_dir = {$urandom, $urandom};
      applyStimulus(nres, nr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
